// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory/writeback stage: funct3 encodings,
// FSM states and small legality/alignment helpers.
package mem_stage_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2
    } state_e;

    // Loads allow B/H/W/BU/HU; stores allow only B/H/W.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    // Access size lives in funct3[1:0] for every legal encoding.
    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return (off[0] == 1'b0);
            2'b10:   return (off == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Combinational load lane selection and sign/zero extension of a read word.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half lane, then extend according to funct3.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data_o   = rdata_i;
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'h000000, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'h0000, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory/writeback stage: issues loads/stores on a req/ack port and
// produces a registered one-cycle writeback; non-memory results pass through.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_funct3,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [31:0] in_result,
    input  logic [31:0] in_store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);

    state_e      state_q;
    logic        mem_req_q, mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic        wb_valid_q, wb_we_q, err_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    // In-flight instruction context, only meaningful while in MEM.
    logic [4:0]  rd_q;
    logic        ld_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        accept;
    logic        is_mem;
    logic        bad_access;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] ld_ext;

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign in_ready = (state_q != MEM);
    assign accept   = in_valid && in_ready;

    // Decode the incoming instruction: legality, alignment and store lanes.
    always_comb begin
        is_mem     = in_is_load || in_is_store;
        bad_access = !f3_legal(in_is_load, in_funct3) ||
                     !f3_aligned(in_funct3, in_result[1:0]);
        wstrb_d    = in_is_store ? store_strb(in_funct3, in_result[1:0]) : 4'b0000;
        wdata_d    = store_lanes(in_funct3, in_store_data);
    end

    load_extend u_load_extend (
        .rdata_i  (mem_rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (ld_ext)
    );

    // Stage FSM with registered memory-port and writeback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                MEM: begin
                    if (mem_ack) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                        wb_valid_q  <= 1'b1;
                        wb_rd_q     <= rd_q;
                        wb_we_q     <= ld_q && (rd_q != 5'd0);
                        wb_data_q   <= ld_q ? ld_ext : 32'h0;
                        state_q     <= WB;
                    end
                end
                default: begin
                    if (accept) begin
                        if (!is_mem) begin
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= (in_rd != 5'd0);
                            wb_rd_q    <= in_rd;
                            wb_data_q  <= in_result;
                            state_q    <= WB;
                        end else if (bad_access) begin
                            wb_valid_q <= 1'b1;
                            err_q      <= 1'b1;
                            wb_rd_q    <= in_rd;
                            wb_data_q  <= 32'h0;
                            state_q    <= WB;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= in_is_store;
                            mem_addr_q  <= {in_result[31:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                            mem_wstrb_q <= wstrb_d;
                            state_q     <= MEM;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // Capture the context needed to finish a memory access.
    always_ff @(posedge clk) begin
        if (state_q != MEM && accept) begin
            rd_q  <= in_rd;
            ld_q  <= in_is_load;
            f3_q  <= in_funct3;
            off_q <= in_result[1:0];
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_is_load = 1'b0;
    logic        in_is_store = 1'b0;
    logic [31:0] in_result = '0;
    logic [31:0] in_store_data = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_wb_data;
    logic        last_wb_we;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_funct3(in_funct3), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_result(in_result), .in_store_data(in_store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: value a load writes back, from plain shifts and arithmetic.
    function automatic logic [31:0] model_load(input logic [31:0] rdat, input logic [31:0] addr,
                                               input logic [2:0] f3);
        int unsigned size;
        logic [31:0] w, v;
        size = 1 << (f3 % 4);
        w = rdat >> (8 * (addr % 4));
        v = rdat;
        if (size == 1) begin
            v = w & 32'hFF;
            if (f3 < 4 && v >= 128) v = v - 256;
        end else if (size == 2) begin
            v = w & 32'hFFFF;
            if (f3 < 4 && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    // Drive one instruction, play memory with 'lat' cycles to ack, check everything.
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] res, input logic [31:0] sd,
                          input logic [31:0] rdat, input int lat);
        bit is_mem, legal, ok;
        int unsigned size, off;
        logic [31:0] e_strb, e_wdata, e_addr;
        is_mem = ld || st;
        legal  = ld ? (f3 != 3 && f3 != 6 && f3 != 7) : (f3 <= 2);
        size   = 1 << (f3 % 4);
        off    = res % 4;
        ok     = is_mem && legal && ((res % size) == 0);
        e_addr = res - off;
        e_strb = st ? (((1 << size) - 1) << off) : 0;
        if (size == 1)      e_wdata = (sd & 32'hFF) * 32'h0101_0101;
        else if (size == 2) e_wdata = (sd & 32'hFFFF) * 32'h0001_0001;
        else                e_wdata = sd;

        @(negedge clk);
        chk("in_ready_before", in_ready, 1);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_rd = rd; in_result = res; in_store_data = sd;
        @(posedge clk); #1;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_result = $urandom; in_store_data = $urandom;
        if (ok) begin
            for (int j = 1; j <= lat; j++) begin
                chk("mem_req", mem_req, 1);
                chk("mem_we", mem_we, st);
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wstrb", mem_wstrb, e_strb);
                if (st) chk("mem_wdata", mem_wdata, e_wdata);
                chk("in_ready_mem", in_ready, 0);
                chk("wb_valid_mem", wb_valid, 0);
                if (j == lat) begin
                    mem_ack = 1'b1; mem_rdata = rdat;
                end else begin
                    mem_rdata = $urandom;
                end
                @(posedge clk); #1;
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
            chk("wb_valid", wb_valid, 1);
            chk("wb_we", wb_we, ld && rd != 0);
            chk("wb_rd", wb_rd, rd);
            chk("err_mem", err, 0);
            chk("mem_req_after_ack", mem_req, 0);
            chk("in_ready_wb", in_ready, 1);
            if (ld && rd != 0) chk("wb_data_load", wb_data, model_load(rdat, res, f3));
        end else begin
            chk("wb_valid", wb_valid, 1);
            chk("err", err, is_mem);
            chk("wb_we", wb_we, !is_mem && rd != 0);
            chk("wb_rd", wb_rd, rd);
            chk("mem_req_none", mem_req, 0);
            if (!is_mem) chk("wb_data_pass", wb_data, res);
        end
        last_wb_data = wb_data;
        last_wb_we   = wb_we;
        @(posedge clk); #1;
        chk("wb_valid_drop", wb_valid, 0);
        chk("err_drop", err, 0);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back pass-through.
        @(negedge clk);
        in_valid = 1'b1; in_rd = 5'd5; in_result = 32'h1234_5678;
        @(posedge clk); #1;
        chk("b2b_v0", wb_valid, 1);
        chk("b2b_d0", wb_data, 32'h1234_5678);
        chk("b2b_we0", wb_we, 1);
        chk("b2b_rd0", wb_rd, 5);
        chk("b2b_ready", in_ready, 1);
        in_rd = 5'd7; in_result = 32'hCAFE_F00D;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_v1", wb_valid, 1);
        chk("b2b_d1", wb_data, 32'hCAFE_F00D);
        chk("b2b_rd1", wb_rd, 7);
        @(posedge clk); #1;
        chk("b2b_idle", wb_valid, 0);

        // Directed memory cases.
        run_op(0, 1, 3'b000, 5'd9, 32'h0000_0103, 32'h0000_00AB, 32'h0, 4);
        chk("sb_wb_we", last_wb_we, 0);
        run_op(1, 0, 3'b000, 5'd4, 32'h0000_0202, 32'h0, 32'h0080_0000, 1);
        chk("lb_const", last_wb_data, 32'hFFFF_FF80);
        run_op(1, 0, 3'b100, 5'd4, 32'h0000_0202, 32'h0, 32'h0080_0000, 2);
        chk("lbu_const", last_wb_data, 32'h0000_0080);
        run_op(1, 0, 3'b101, 5'd4, 32'h0000_0202, 32'h0, 32'h8001_0000, 1);
        chk("lhu_const", last_wb_data, 32'h0000_8001);
        run_op(1, 0, 3'b010, 5'd6, 32'h0000_0201, 32'h0, 32'h0, 1);
        run_op(1, 0, 3'b111, 5'd6, 32'h0000_0200, 32'h0, 32'h0, 1);
        run_op(1, 0, 3'b010, 5'd0, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 2);
        chk("ld_rd0_we", last_wb_we, 0);

        // Reset while a request is outstanding, then a stray ack in IDLE.
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'b010; in_rd = 5'd3;
        in_result = 32'h0000_0300;
        @(posedge clk); #1;
        in_valid = 1'b0; in_is_load = 1'b0;
        chk("rstmem_req", mem_req, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmem_req_drop", mem_req, 0);
        chk("rstmem_wb", wb_valid, 0);
        chk("rstmem_ready", in_ready, 1);
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("late_ack_wb", wb_valid, 0);
        chk("late_ack_req", mem_req, 0);
        @(posedge clk); #1;
        chk("late_ack_wb2", wb_valid, 0);

        // Randomized mix.
        for (int i = 0; i < 200; i++) begin
            int unsigned kind;
            logic [4:0] rd;
            kind = $urandom_range(0, 2);
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            run_op(kind == 1, kind == 2, 3'($urandom), rd, $urandom, $urandom, $urandom,
                   int'($urandom_range(1, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
